trace_capture_ctrl: RTL

//  Sequences one TDC trace capture per arm: waits for the AES trigger, applies a programmable

---
 rtl/trace_capture_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/trace_capture_ctrl.sv
// Sequences one TDC trace capture per arm: trigger -> programmable delay -> tdc_start pulse
// -> burst watch, and hands the trace memory to the host for readout afterwards.
module trace_capture_ctrl #(
  parameter int unsigned DELAY_W = 16,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_sample,
  input  logic               lbus_rstn,
  input  logic               cfg_arm,
  input  logic               cfg_abort,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic               trig_in,
  input  logic               trc_we,
  input  logic               rd_req,
  output logic               tdc_start,
  output logic               mem_owner,
  output logic               rd_gnt,
  output logic               trace_ready,
  output logic               busy,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   trace_cnt,
  output logic [7:0]         missed_trig,
  output logic [2:0]         state_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_START   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5,
    S_READOUT = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_trig_prev;
  logic               w_trig_edge;
  logic [DELAY_W-1:0] r_dly_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_we_seen;
  logic               r_tdc_start;
  logic               r_mem_owner;
  logic               r_rd_gnt;
  logic               r_trace_ready;
  logic               r_busy;
  logic               r_err_timeout;
  logic [CNT_W-1:0]   r_trace_cnt;
  logic [7:0]         r_missed;

  assign w_trig_edge = trig_in & ~r_trig_prev;

  always_comb begin
    w_next = r_state;
    if (cfg_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (cfg_arm) w_next = S_ARMED;
        S_ARMED:   if (w_trig_edge) w_next = S_DELAY;
        S_DELAY:   if (r_dly_cnt == '0) w_next = S_START;
        S_START:   w_next = S_CAPTURE;
        // Burst completion takes priority over a timeout landing on the same cycle.
        S_CAPTURE: begin
          if (!trc_we && r_we_seen)                    w_next = S_DONE;
          else if (r_to_cnt == TO_W'(TIMEOUT - 1))     w_next = S_ERROR;
        end
        S_DONE:    if (rd_req) w_next = S_READOUT;
        S_READOUT: if (!rd_req) w_next = S_IDLE;
        S_ERROR:   if (cfg_arm) w_next = S_ARMED;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk_sample or negedge lbus_rstn) begin
    if (!lbus_rstn) begin
      r_state       <= S_IDLE;
      r_trig_prev   <= 1'b0;
      r_dly_cnt     <= '0;
      r_to_cnt      <= '0;
      r_we_seen     <= 1'b0;
      r_tdc_start   <= 1'b0;
      r_mem_owner   <= 1'b0;
      r_rd_gnt      <= 1'b0;
      r_trace_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_trace_cnt   <= '0;
      r_missed      <= '0;
    end else begin
      r_state     <= w_next;
      r_trig_prev <= trig_in;

      if (r_state == S_ARMED && w_next == S_DELAY)
        r_dly_cnt <= cfg_delay;
      else if (r_state == S_DELAY && r_dly_cnt != '0)
        r_dly_cnt <= r_dly_cnt - DELAY_W'(1);

      if (r_state == S_START) begin
        r_to_cnt  <= '0;
        r_we_seen <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
        if (trc_we) r_we_seen <= 1'b1;
      end

      r_tdc_start   <= (r_state == S_START) && (w_next == S_CAPTURE);
      r_mem_owner   <= (w_next == S_READOUT);
      r_rd_gnt      <= (w_next == S_READOUT);
      r_trace_ready <= (w_next == S_DONE);
      r_busy        <= !(w_next == S_IDLE || w_next == S_DONE || w_next == S_ERROR);

      if (r_state != S_DONE && w_next == S_DONE)
        r_trace_cnt <= r_trace_cnt + CNT_W'(1);

      if (r_state != S_ERROR && w_next == S_ERROR)
        r_err_timeout <= 1'b1;
      else if (r_state == S_ERROR && w_next == S_ARMED)
        r_err_timeout <= 1'b0;

      if (w_trig_edge && r_state != S_ARMED && r_missed != 8'hFF)
        r_missed <= r_missed + 8'd1;
    end
  end

  assign tdc_start   = r_tdc_start;
  assign mem_owner   = r_mem_owner;
  assign rd_gnt      = r_rd_gnt;
  assign trace_ready = r_trace_ready;
  assign busy        = r_busy;
  assign err_timeout = r_err_timeout;
  assign trace_cnt   = r_trace_cnt;
  assign missed_trig = r_missed;
  assign state_o     = r_state;

endmodule
